multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its
// datapath/memory. The controller owns the master side.
interface multicycle_ctrl_if;
    logic       run;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        input  run, opcode, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, instr_done,
               fault, fault_code
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, instr_done,
               fault, fault_code
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: fetch/decode/execute sequencing for
// load, store, R-type and beq, with a memory-wait watchdog and a sticky fault.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_ALUWB, S_BEQ, S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       fault_q, fault_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       wait_expired;
    logic       mem_req_int;
    state_t     end_state;

    assign wait_expired = (wait_cnt_q == WAIT_LAST);
    assign end_state    = bus.run ? S_FETCH : S_IDLE;
    assign mem_req_int  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);

    // Next-state and fault capture; a ready in the timeout cycle completes normally.
    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    state_d = S_MEMADR;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = S_EXECR;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            // Bit 5 separates store (1) from load (0) among the memory opcodes.
            S_MEMADR: state_d = bus.opcode[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_MEMWB:  state_d = end_state;
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = end_state;
                end else if (wait_expired) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_EXECR:  state_d = S_ALUWB;
            S_ALUWB:  state_d = end_state;
            S_BEQ:    state_d = end_state;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, fault and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            if (state_d != state_q &&
                (state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR)) begin
                wait_cnt_q <= 8'd0;
            end else if (mem_req_int && !bus.mem_ready) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
        end
    end

    // Output decode from state; everything forced low while reset is asserted.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        bus.instr_done = 1'b0;
        bus.fault      = 1'b0;
        bus.fault_code = 2'b00;
        if (rst_n) begin
            bus.fault      = fault_q;
            bus.fault_code = fault_code_q;
            unique case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req    = 1'b1;
                    bus.mem_we     = 1'b1;
                    bus.adr_src    = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXECR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a  = 2'b10;
                    bus.alu_op     = 2'b01;
                    bus.pc_write   = bus.zero;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each cycle's expected output vector is queued
// when the inputs are driven and compared when the DUT outputs are sampled.
module tb_multicycle_ctrl;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output vector: {req,we,adr,irw,pcw,rw,srca,srcb,aluop,res,done,fault,code}
    function automatic logic [17:0] mk(logic req, logic we, logic adr, logic irw,
                                       logic pcw, logic rw, logic [1:0] sa,
                                       logic [1:0] sb, logic [1:0] op,
                                       logic [1:0] rs, logic done, logic flt,
                                       logic [1:0] fc);
        return {req, we, adr, irw, pcw, rw, sa, sb, op, rs, done, flt, fc};
    endfunction

    function automatic logic [17:0] e_fetch(logic mr);
        return mk(1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_dec();
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_madr();
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_mrd();
        return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_mwb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_mwr(logic mr);
        return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, mr, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_exe();
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_awb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_beq(logic z);
        return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00);
    endfunction
    function automatic logic [17:0] e_flt(logic [1:0] c);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, c);
    endfunction

    function automatic logic [17:0] observed();
        return {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.result_src, bus.instr_done, bus.fault, bus.fault_code};
    endfunction

    task automatic check(string tag, logic [17:0] got, logic [17:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%05h want=%05h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare on the falling edge.
    task automatic cyc(logic rn, logic r, logic [6:0] opc, logic z, logic mr,
                       logic [17:0] e, string tag);
        rst_n         = rn;
        bus.run       = r;
        bus.opcode    = opc;
        bus.zero      = z;
        bus.mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check(tag_q.pop_front(), observed(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.opcode = R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset and idle behaviour
        cyc(0, 0, R, 0, 0, 18'd0, "rst");
        cyc(1, 0, R, 0, 1, 18'd0, "idle_ign_rdy");
        cyc(1, 0, R, 0, 0, 18'd0, "idle");

        // R-type, 4 cycles
        cyc(1, 1, R, 0, 1, 18'd0,       "r_idle");
        cyc(1, 1, R, 0, 1, e_fetch(1),  "r_fetch");
        cyc(1, 1, R, 0, 1, e_dec(),     "r_dec");
        cyc(1, 1, R, 0, 1, e_exe(),     "r_exec");
        cyc(1, 0, R, 0, 1, e_awb(),     "r_aluwb");
        cyc(1, 0, R, 0, 0, 18'd0,       "r_end_idle");

        // load: two fetch waits, then three MEMRD waits (counter cleared between)
        cyc(1, 1, LD, 0, 0, 18'd0,      "ld_idle");
        cyc(1, 1, LD, 0, 0, e_fetch(0), "ld_fetch_w0");
        cyc(1, 1, LD, 0, 0, e_fetch(0), "ld_fetch_w1");
        cyc(1, 1, LD, 0, 1, e_fetch(1), "ld_fetch");
        cyc(1, 1, LD, 0, 1, e_dec(),    "ld_dec");
        cyc(1, 1, LD, 0, 1, e_madr(),   "ld_madr");
        cyc(1, 1, LD, 0, 0, e_mrd(),    "ld_mrd_w0");
        cyc(1, 1, LD, 0, 0, e_mrd(),    "ld_mrd_w1");
        cyc(1, 1, LD, 0, 0, e_mrd(),    "ld_mrd_w2");
        cyc(1, 1, LD, 0, 1, e_mrd(),    "ld_mrd_rdy");
        cyc(1, 0, LD, 0, 1, e_mwb(),    "ld_mwb");
        cyc(1, 0, LD, 0, 0, 18'd0,      "ld_end_idle");

        // beq taken, then back-to-back beq not taken
        cyc(1, 1, BQ, 1, 1, 18'd0,      "bq_idle");
        cyc(1, 1, BQ, 1, 1, e_fetch(1), "bq1_fetch");
        cyc(1, 1, BQ, 1, 1, e_dec(),    "bq1_dec");
        cyc(1, 1, BQ, 1, 1, e_beq(1),   "bq1_taken");
        cyc(1, 1, BQ, 0, 1, e_fetch(1), "bq2_fetch");
        cyc(1, 1, BQ, 0, 1, e_dec(),    "bq2_dec");
        cyc(1, 0, BQ, 0, 1, e_beq(0),   "bq2_not_taken");
        cyc(1, 0, BQ, 0, 0, 18'd0,      "bq_end_idle");

        // store with run dropped on completion
        cyc(1, 1, ST, 0, 1, 18'd0,      "st_idle");
        cyc(1, 1, ST, 0, 1, e_fetch(1), "st_fetch");
        cyc(1, 1, ST, 0, 1, e_dec(),    "st_dec");
        cyc(1, 1, ST, 0, 1, e_madr(),   "st_madr");
        cyc(1, 1, ST, 0, 0, e_mwr(0),   "st_mwr_wait");
        cyc(1, 0, ST, 0, 1, e_mwr(1),   "st_mwr_done");
        cyc(1, 0, ST, 0, 0, 18'd0,      "st_end_idle");

        // store interrupted by reset in MEMWR
        cyc(1, 1, ST, 0, 1, 18'd0,      "str_idle");
        cyc(1, 1, ST, 0, 1, e_fetch(1), "str_fetch");
        cyc(1, 1, ST, 0, 1, e_dec(),    "str_dec");
        cyc(1, 1, ST, 0, 1, e_madr(),   "str_madr");
        cyc(0, 1, ST, 0, 1, 18'd0,      "str_rst_in_mwr");
        cyc(1, 0, ST, 0, 1, 18'd0,      "str_after_rst");

        // illegal opcode: sticky fault, run ignored, cleared by reset
        cyc(1, 1, BAD, 0, 1, 18'd0,          "ill_idle");
        cyc(1, 1, BAD, 0, 1, e_fetch(1),     "ill_fetch");
        cyc(1, 0, BAD, 0, 1, e_dec(),        "ill_dec");
        cyc(1, 0, BAD, 0, 1, e_flt(2'b01),   "ill_fault_a");
        cyc(1, 1, BAD, 0, 1, e_flt(2'b01),   "ill_fault_b");
        cyc(1, 0, R,   0, 1, e_flt(2'b01),   "ill_fault_c");
        cyc(0, 0, R,   0, 0, 18'd0,          "ill_rst");
        cyc(1, 0, R,   0, 0, 18'd0,          "ill_idle_after");

        // fetch timeout after exactly 4 wait cycles
        cyc(1, 1, R, 0, 0, 18'd0,        "to_idle");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "to_fetch1");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "to_fetch2");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "to_fetch3");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "to_fetch4");
        cyc(1, 1, R, 0, 0, e_flt(2'b10), "to_fault");
        cyc(1, 1, R, 0, 1, e_flt(2'b10), "to_fault_held");
        cyc(0, 0, R, 0, 0, 18'd0,        "to_rst");

        // ready arriving in the 4th fetch cycle wins over the timeout
        cyc(1, 1, R, 0, 0, 18'd0,        "rw_idle");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "rw_fetch1");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "rw_fetch2");
        cyc(1, 1, R, 0, 0, e_fetch(0),   "rw_fetch3");
        cyc(1, 1, R, 0, 1, e_fetch(1),   "rw_fetch4_rdy");
        cyc(1, 1, R, 0, 0, e_dec(),      "rw_dec");
        cyc(1, 1, R, 0, 0, e_exe(),      "rw_exec");
        cyc(1, 0, R, 0, 0, e_awb(),      "rw_aluwb");
        cyc(1, 0, R, 0, 0, 18'd0,        "rw_end_idle");

        // MEMRD timeout
        cyc(1, 1, LD, 0, 1, 18'd0,        "tr_idle");
        cyc(1, 1, LD, 0, 1, e_fetch(1),   "tr_fetch");
        cyc(1, 1, LD, 0, 1, e_dec(),      "tr_dec");
        cyc(1, 1, LD, 0, 1, e_madr(),     "tr_madr");
        cyc(1, 1, LD, 0, 0, e_mrd(),      "tr_mrd1");
        cyc(1, 1, LD, 0, 0, e_mrd(),      "tr_mrd2");
        cyc(1, 1, LD, 0, 0, e_mrd(),      "tr_mrd3");
        cyc(1, 1, LD, 0, 0, e_mrd(),      "tr_mrd4");
        cyc(1, 1, LD, 0, 0, e_flt(2'b10), "tr_fault");
        cyc(0, 0, LD, 0, 0, 18'd0,        "tr_rst");
        cyc(1, 0, LD, 0, 0, 18'd0,        "tr_idle_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
